// File: rtl/xif_coproc_arbiter.sv
// Shares one CORE-V-XIF coprocessor between two cores: round-robin issue arbitration,
// requester-tagged transaction IDs, tag-routed results and per-requester write-back credit limits.
module xif_coproc_arbiter #(
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [1:0]              req_issue_valid_i,
   output logic [1:0]              req_issue_ready_o,
   input  logic [63:0]             req_issue_instr_i,
   input  logic [127:0]            req_issue_rs_i,
   input  logic [2*ID_WIDTH-1:0]   req_issue_id_i,
   output logic [1:0]              req_issue_accept_o,
   output logic [1:0]              req_issue_writeback_o,
   output logic [1:0]              req_result_valid_o,
   input  logic [1:0]              req_result_ready_i,
   output logic [ID_WIDTH-1:0]     req_result_id_o,
   output logic [31:0]             req_result_data_o,
   output logic [4:0]              req_result_rd_o,
   output logic                    req_result_we_o,
   output logic                    cop_issue_valid_o,
   input  logic                    cop_issue_ready_i,
   output logic [31:0]             cop_issue_instr_o,
   output logic [63:0]             cop_issue_rs_o,
   output logic [ID_WIDTH:0]       cop_issue_id_o,
   input  logic                    cop_issue_accept_i,
   input  logic                    cop_issue_writeback_i,
   input  logic                    cop_result_valid_i,
   output logic                    cop_result_ready_o,
   input  logic [ID_WIDTH:0]       cop_result_id_i,
   input  logic [31:0]             cop_result_data_i,
   input  logic [4:0]              cop_result_rd_i,
   input  logic                    cop_result_we_i,
   output logic                    err_o
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   logic            rr_ptr;
   logic            lock;
   logic            lock_idx;
   logic [1:0][3:0] cnt;
   logic            err;

   logic [1:0] elig;
   logic       grant_vld;
   logic       grant_idx;
   logic       issue_hs;
   logic       rsel;
   logic       cnt_zero;
   logic [1:0] inc;
   logic [1:0] dec;

   assign elig[0] = req_issue_valid_i[0] && (cnt[0] < MAX_CNT);
   assign elig[1] = req_issue_valid_i[1] && (cnt[1] < MAX_CNT);

   // A stalled handshake keeps its grant so the coprocessor sees stable fields until ready.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      grant_vld = 1'b0;
      grant_idx = 1'b0;
      if (lock) begin
         grant_vld = req_issue_valid_i[lock_idx];
         grant_idx = lock_idx;
      end else if (elig[rr_ptr]) begin
         grant_vld = 1'b1;
         grant_idx = rr_ptr;
      end else if (elig[!rr_ptr]) begin
         grant_vld = 1'b1;
         grant_idx = !rr_ptr;
      end
   end

   assign issue_hs = grant_vld && cop_issue_ready_i;

   always_comb begin
      cop_issue_valid_o     = grant_vld;
      cop_issue_instr_o     = '0;
      cop_issue_rs_o        = '0;
      cop_issue_id_o        = '0;
      req_issue_ready_o     = '0;
      req_issue_accept_o    = '0;
      req_issue_writeback_o = '0;
      if (grant_vld) begin
         cop_issue_instr_o = grant_idx ? req_issue_instr_i[63:32] : req_issue_instr_i[31:0];
         cop_issue_rs_o    = grant_idx ? req_issue_rs_i[127:64] : req_issue_rs_i[63:0];
         cop_issue_id_o    = {grant_idx, grant_idx ? req_issue_id_i[ID_WIDTH +: ID_WIDTH]
                                                   : req_issue_id_i[0 +: ID_WIDTH]};
         req_issue_ready_o[grant_idx]     = cop_issue_ready_i;
         req_issue_accept_o[grant_idx]    = cop_issue_accept_i;
         req_issue_writeback_o[grant_idx] = cop_issue_writeback_i;
      end
   end

   // Results for a requester with no credit outstanding are swallowed and flagged.
   assign rsel     = cop_result_id_i[ID_WIDTH];
   assign cnt_zero = (cnt[rsel] == 4'd0);

   always_comb begin
      req_result_valid_o = '0;
      if (!cnt_zero) begin
         req_result_valid_o[rsel] = cop_result_valid_i;
      end
      cop_result_ready_o = cnt_zero ? cop_result_valid_i : req_result_ready_i[rsel];
   end

   assign req_result_id_o   = cop_result_id_i[ID_WIDTH-1:0];
   assign req_result_data_o = cop_result_data_i;
   assign req_result_rd_o   = cop_result_rd_i;
   assign req_result_we_o   = cop_result_we_i;
   assign err_o             = err;

   always_comb begin
      inc = '0;
      dec = '0;
      inc[grant_idx] = issue_hs && cop_issue_accept_i && cop_issue_writeback_i;
      dec[rsel]      = cop_result_valid_i && cop_result_ready_o && !cnt_zero;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst_i) begin
         rr_ptr   <= 1'b0;
         lock     <= 1'b0;
         lock_idx <= 1'b0;
         cnt      <= '0;
         err      <= 1'b0;
      end else begin
         if (issue_hs) begin
            rr_ptr <= !grant_idx;
            lock   <= 1'b0;
         end else if (grant_vld) begin
            lock     <= 1'b1;
            lock_idx <= grant_idx;
         end
         for (int r = 0; r < 2; r++) begin
            if (inc[r] && !dec[r]) begin
               cnt[r] <= cnt[r] + 4'd1;
            end else if (dec[r] && !inc[r]) begin
               cnt[r] <= cnt[r] - 4'd1;
            end
         end
         if (cop_result_valid_i && cnt_zero) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Scoreboard bench for xif_coproc_arbiter: stimulus pushes expected issue/result transactions,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_xif_coproc_arbiter;

   localparam int ID_WIDTH = 4;
   localparam logic [3:0]  ID0 = 4'h3;
   localparam logic [3:0]  ID1 = 4'h5;
   localparam logic [31:0] I0  = 32'h1111_0000;
   localparam logic [31:0] I1  = 32'h2222_0001;
   localparam logic [63:0] RS0 = 64'h0000_00AA_0000_0055;
   localparam logic [63:0] RS1 = 64'h0000_0BBB_0000_0CCC;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [1:0]            req_issue_valid_i;
   logic [1:0]            req_issue_ready_o;
   logic [63:0]           req_issue_instr_i;
   logic [127:0]          req_issue_rs_i;
   logic [2*ID_WIDTH-1:0] req_issue_id_i;
   logic [1:0]            req_issue_accept_o;
   logic [1:0]            req_issue_writeback_o;
   logic [1:0]            req_result_valid_o;
   logic [1:0]            req_result_ready_i;
   logic [ID_WIDTH-1:0]   req_result_id_o;
   logic [31:0]           req_result_data_o;
   logic [4:0]            req_result_rd_o;
   logic                  req_result_we_o;
   logic                  cop_issue_valid_o;
   logic                  cop_issue_ready_i;
   logic [31:0]           cop_issue_instr_o;
   logic [63:0]           cop_issue_rs_o;
   logic [ID_WIDTH:0]     cop_issue_id_o;
   logic                  cop_issue_accept_i;
   logic                  cop_issue_writeback_i;
   logic                  cop_result_valid_i;
   logic                  cop_result_ready_o;
   logic [ID_WIDTH:0]     cop_result_id_i;
   logic [31:0]           cop_result_data_i;
   logic [4:0]            cop_result_rd_i;
   logic                  cop_result_we_i;
   logic                  err_o;

   xif_coproc_arbiter #(.ID_WIDTH(ID_WIDTH), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_issue_valid_i(req_issue_valid_i), .req_issue_ready_o(req_issue_ready_o),
      .req_issue_instr_i(req_issue_instr_i), .req_issue_rs_i(req_issue_rs_i),
      .req_issue_id_i(req_issue_id_i), .req_issue_accept_o(req_issue_accept_o),
      .req_issue_writeback_o(req_issue_writeback_o),
      .req_result_valid_o(req_result_valid_o), .req_result_ready_i(req_result_ready_i),
      .req_result_id_o(req_result_id_o), .req_result_data_o(req_result_data_o),
      .req_result_rd_o(req_result_rd_o), .req_result_we_o(req_result_we_o),
      .cop_issue_valid_o(cop_issue_valid_o), .cop_issue_ready_i(cop_issue_ready_i),
      .cop_issue_instr_o(cop_issue_instr_o), .cop_issue_rs_o(cop_issue_rs_o),
      .cop_issue_id_o(cop_issue_id_o), .cop_issue_accept_i(cop_issue_accept_i),
      .cop_issue_writeback_i(cop_issue_writeback_i),
      .cop_result_valid_i(cop_result_valid_i), .cop_result_ready_o(cop_result_ready_o),
      .cop_result_id_i(cop_result_id_i), .cop_result_data_i(cop_result_data_i),
      .cop_result_rd_i(cop_result_rd_i), .cop_result_we_i(cop_result_we_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [4:0]  id;
      logic [31:0] instr;
      logic [63:0] rs;
      logic [1:0]  rdy;
      logic [1:0]  acc;
   } iss_t;

   typedef struct packed {
      logic [1:0]  vld;
      logic [3:0]  id;
      logic [31:0] data;
   } res_t;

   iss_t iss_q[$];
   res_t res_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic exp_iss(input logic g);
      iss_t e;
      e.id    = {g, g ? ID1 : ID0};
      e.instr = g ? I1 : I0;
      e.rs    = g ? RS1 : RS0;
      e.rdy   = g ? 2'b10 : 2'b01;
      e.acc   = cop_issue_accept_i ? e.rdy : 2'b00;
      iss_q.push_back(e);
   endtask

   task automatic send_result(input logic [4:0] id, input logic [31:0] data);
      res_t e;
      cop_result_valid_i = 1'b1;
      cop_result_id_i    = id;
      cop_result_data_i  = data;
      req_result_ready_i = id[4] ? 2'b10 : 2'b01;
      e.vld  = id[4] ? 2'b10 : 2'b01;
      e.id   = id[3:0];
      e.data = data;
      res_q.push_back(e);
   endtask

   task automatic clear_result();
      cop_result_valid_i = 1'b0;
      cop_result_id_i    = '0;
      cop_result_data_i  = '0;
      req_result_ready_i = 2'b00;
   endtask

   // Monitor: every issue handshake and every delivered result must match the queue head.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (cop_issue_valid_o && cop_issue_ready_i) begin
            if (iss_q.size() == 0) begin
               check("issue_unexpected", {cop_issue_id_o}, 0);
            end else begin
               iss_t e;
               e = iss_q.pop_front();
               check("issue_id", cop_issue_id_o, e.id);
               check("issue_instr", cop_issue_instr_o, e.instr);
               check("issue_rs", cop_issue_rs_o, e.rs);
               check("issue_ready", req_issue_ready_o, e.rdy);
               check("issue_accept", req_issue_accept_o, e.acc);
            end
         end
         if (req_result_valid_o != 2'b00) begin
            if (res_q.size() == 0) begin
               check("result_unexpected", req_result_valid_o, 0);
            end else begin
               res_t r;
               r = res_q.pop_front();
               check("result_valid", req_result_valid_o, r.vld);
               check("result_id", req_result_id_o, r.id);
               check("result_data", req_result_data_o, r.data);
               check("result_cop_ready", cop_result_ready_o, 1'b1);
            end
         end
      end
   end

   initial begin
      rst_i                 = 1'b1;
      req_issue_valid_i     = 2'b00;
      req_issue_instr_i     = '0;
      req_issue_rs_i        = '0;
      req_issue_id_i        = '0;
      req_result_ready_i    = 2'b00;
      cop_issue_ready_i     = 1'b0;
      cop_issue_accept_i    = 1'b0;
      cop_issue_writeback_i = 1'b0;
      cop_result_valid_i    = 1'b0;
      cop_result_id_i       = '0;
      cop_result_data_i     = '0;
      cop_result_rd_i       = '0;
      cop_result_we_i       = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Reset state with all inputs zero.
      @(negedge clk_i);
      check("rst_cop_valid", cop_issue_valid_o, 1'b0);
      check("rst_req_ready", req_issue_ready_o, 2'b00);
      check("rst_cop_id", cop_issue_id_o, 5'h00);
      check("rst_res_valid", req_result_valid_o, 2'b00);
      check("rst_cop_res_ready", cop_result_ready_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      next_cycle();

      req_issue_instr_i = {I1, I0};
      req_issue_rs_i    = {RS1, RS0};
      req_issue_id_i    = {ID1, ID0};

      // Both valid, always ready, no write-back: grants alternate 0,1,0,1.
      req_issue_valid_i  = 2'b11;
      cop_issue_ready_i  = 1'b1;
      cop_issue_accept_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_iss(k[0]);
         @(negedge clk_i);
         next_cycle();
      end

      // Stall on requester 0; requester 1 joins but must wait for the held grant.
      req_issue_valid_i = 2'b01;
      cop_issue_ready_i = 1'b0;
      @(negedge clk_i);
      check("stall_valid", cop_issue_valid_o, 1'b1);
      check("stall_id", cop_issue_id_o, {1'b0, ID0});
      check("stall_ready", req_issue_ready_o, 2'b00);
      next_cycle();
      req_issue_valid_i = 2'b11;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         check("lock_id", cop_issue_id_o, {1'b0, ID0});
         next_cycle();
      end
      cop_issue_ready_i = 1'b1;
      exp_iss(1'b0);
      @(negedge clk_i);
      next_cycle();
      exp_iss(1'b1);
      @(negedge clk_i);
      next_cycle();

      // Requester 0 fills its write-back credit (4), fifth valid is blocked.
      req_issue_valid_i     = 2'b01;
      cop_issue_writeback_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_iss(1'b0);
         @(negedge clk_i);
         next_cycle();
      end
      send_result(5'h03, 32'h0000_0003);
      @(negedge clk_i);
      check("credit_block_valid", cop_issue_valid_o, 1'b0);
      check("credit_block_ready", req_issue_ready_o, 2'b00);
      next_cycle();
      clear_result();
      exp_iss(1'b0);
      @(negedge clk_i);
      check("credit_reenable", cop_issue_valid_o, 1'b1);
      next_cycle();
      req_issue_valid_i = 2'b00;
      for (int k = 0; k < 4; k++) begin
         send_result({1'b0, 4'(k)}, 32'h0A00_0000 + 32'(k));
         @(negedge clk_i);
         next_cycle();
      end
      clear_result();

      // Requester 1 takes two credits, then the 5'h1A result returns one.
      req_issue_valid_i = 2'b10;
      for (int k = 0; k < 2; k++) begin
         exp_iss(1'b1);
         @(negedge clk_i);
         next_cycle();
      end
      req_issue_valid_i = 2'b00;
      send_result(5'h1A, 32'hDEAD_BEEF);
      @(negedge clk_i);
      check("r1a_cop_ready", cop_result_ready_o, 1'b1);
      next_cycle();
      clear_result();

      // Back to 2, then same-cycle issue and result on requester 1 leave it at 2.
      req_issue_valid_i = 2'b10;
      exp_iss(1'b1);
      @(negedge clk_i);
      next_cycle();
      exp_iss(1'b1);
      send_result(5'h15, 32'h0000_1515);
      @(negedge clk_i);
      next_cycle();
      clear_result();
      for (int k = 0; k < 2; k++) begin
         exp_iss(1'b1);
         @(negedge clk_i);
         next_cycle();
      end
      @(negedge clk_i);
      check("r1_full_block", cop_issue_valid_o, 1'b0);
      next_cycle();
      req_issue_valid_i = 2'b00;
      for (int k = 0; k < 4; k++) begin
         send_result({1'b1, 4'(k + 4)}, 32'h0B00_0000 + 32'(k));
         @(negedge clk_i);
         next_cycle();
      end
      clear_result();
      @(negedge clk_i);
      check("err_clean", err_o, 1'b0);
      next_cycle();

      // Result for requester 0 with no credit: dropped, sticky error.
      cop_result_valid_i = 1'b1;
      cop_result_id_i    = 5'h07;
      cop_result_data_i  = 32'h0000_0777;
      req_result_ready_i = 2'b00;
      @(negedge clk_i);
      check("drop_valid", req_result_valid_o, 2'b00);
      check("drop_cop_ready", cop_result_ready_o, 1'b1);
      check("drop_err_same_cycle", err_o, 1'b0);
      next_cycle();
      clear_result();
      @(negedge clk_i);
      check("err_set", err_o, 1'b1);
      next_cycle();
      @(negedge clk_i);
      check("err_sticky", err_o, 1'b1);
      next_cycle();
      rst_i = 1'b1;
      next_cycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("err_cleared", err_o, 1'b0);
      check("post_rst_cop_ready", cop_result_ready_o, 1'b0);

      check("iss_q_drained", iss_q.size(), 0);
      check("res_q_drained", res_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
